// File: rtl/tlp_inject_builder_if.sv
// Handshake bundle between the UART command path, the TLP injection mux
// and the builder. The builder side is the master: it drives the TLP word
// stream, the ACK/NAK byte and the status outputs.
interface tlp_inject_builder_if;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  logic [31:0] tlp_data;
  logic        tlp_valid;
  logic        tlp_ready;
  logic        tlp_last;
  logic [7:0]  resp_byte;
  logic        resp_valid;
  logic        resp_ready;
  logic        busy;
  logic [15:0] tlp_count;

  modport master (
    input  rx_byte, rx_byte_valid, tlp_ready, resp_ready,
    output tlp_data, tlp_valid, tlp_last, resp_byte, resp_valid, busy, tlp_count
  );

  modport slave (
    output rx_byte, rx_byte_valid, tlp_ready, resp_ready,
    input  tlp_data, tlp_valid, tlp_last, resp_byte, resp_valid, busy, tlp_count
  );
endinterface

// File: rtl/tlp_inject_builder.sv
// Parses 11-byte UART command frames (SYNC OPC A3..A0 D3..D0 CHK) and turns
// each good frame into a 32-bit PCIe MWr (4 DW) or MRd (3 DW) offered word
// by word to the injection mux, followed by an ACK/NAK byte to the UART TX.
module tlp_inject_builder #(
  parameter logic [15:0] REQ_ID         = 16'h0100,
  parameter logic [7:0]  SYNC_BYTE      = 8'hAA,
  parameter int          TIMEOUT_CYCLES = 125000
) (
  input logic                  pcie_clk,
  input logic                  pcie_reset_n,
  tlp_inject_builder_if.master tlp_io
);

  localparam int              TW           = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]   TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      ACK          = 8'h06;
  localparam logic [7:0]      NAK          = 8'h15;
  localparam logic [7:0]      OPC_MWR      = 8'h01;
  localparam logic [7:0]      OPC_MRD      = 8'h02;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    CHECK,
    EMIT,
    RESP
  } state_t;

  state_t        state_q;
  logic [3:0]    byte_cnt_q;
  logic [71:0]   frame_q;
  logic [7:0]    xor_q;
  logic [7:0]    chk_q;
  logic [TW-1:0] timer_q;
  logic [7:0]    tag_q;
  logic [1:0]    word_idx_q;
  logic [31:0]   tlp_data_q;
  logic          tlp_valid_q;
  logic          tlp_last_q;
  logic [7:0]    resp_byte_q;
  logic          resp_valid_q;
  logic          busy_q;
  logic [15:0]   tlp_count_q;

  logic [7:0]    opc;
  logic          is_wr;
  logic [1:0]    last_idx;
  logic          frame_err;
  logic [31:0]   word_d;

  // frame_q holds OPC in [71:64], address in [63:32], data in [31:0]
  assign opc       = frame_q[71:64];
  assign is_wr     = (opc == OPC_MWR);
  assign last_idx  = is_wr ? 2'd3 : 2'd2;
  assign frame_err = (xor_q != chk_q) ||
                     ((opc != OPC_MWR) && (opc != OPC_MRD)) ||
                     (frame_q[33:32] != 2'b00);

  // Select the TLP header/payload word for the index about to be loaded
  always_comb begin
    word_d = 32'h0;
    unique case (word_idx_q)
      2'd0:    word_d = is_wr ? 32'h4000_0001 : 32'h0000_0001;
      2'd1:    word_d = {REQ_ID, tag_q, 8'h0F};
      2'd2:    word_d = {frame_q[63:34], 2'b00};
      default: word_d = frame_q[31:0];
    endcase
  end

  // Frame parser, checker, word emitter and response FSM with registered outputs
  always_ff @(posedge pcie_clk or negedge pcie_reset_n) begin
    if (!pcie_reset_n) begin
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      frame_q      <= '0;
      xor_q        <= '0;
      chk_q        <= '0;
      timer_q      <= '0;
      tag_q        <= '0;
      word_idx_q   <= '0;
      tlp_data_q   <= '0;
      tlp_valid_q  <= 1'b0;
      tlp_last_q   <= 1'b0;
      resp_byte_q  <= '0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      tlp_count_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (tlp_io.rx_byte_valid && (tlp_io.rx_byte == SYNC_BYTE)) begin
            state_q    <= COLLECT;
            busy_q     <= 1'b1;
            byte_cnt_q <= '0;
            xor_q      <= '0;
            timer_q    <= '0;
          end
        end

        COLLECT: begin
          if (tlp_io.rx_byte_valid) begin
            timer_q <= '0;
            if (byte_cnt_q == 4'd9) begin
              chk_q   <= tlp_io.rx_byte;
              state_q <= CHECK;
            end else begin
              frame_q    <= {frame_q[63:0], tlp_io.rx_byte};
              xor_q      <= xor_q ^ tlp_io.rx_byte;
              byte_cnt_q <= byte_cnt_q + 4'd1;
            end
          end else if (timer_q == TIMEOUT_LAST) begin
            resp_byte_q <= NAK;
            state_q     <= RESP;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        CHECK: begin
          if (frame_err) begin
            resp_byte_q <= NAK;
            state_q     <= RESP;
          end else begin
            word_idx_q <= '0;
            state_q    <= EMIT;
          end
        end

        EMIT: begin
          if (tlp_valid_q && tlp_io.tlp_ready && tlp_last_q) begin
            tlp_valid_q <= 1'b0;
            tlp_last_q  <= 1'b0;
            tag_q       <= tag_q + 8'd1;
            tlp_count_q <= tlp_count_q + 16'd1;
            resp_byte_q <= ACK;
            state_q     <= RESP;
          end else if (!tlp_valid_q || tlp_io.tlp_ready) begin
            tlp_data_q  <= word_d;
            tlp_valid_q <= 1'b1;
            tlp_last_q  <= (word_idx_q == last_idx);
            word_idx_q  <= word_idx_q + 2'd1;
          end
        end

        RESP: begin
          if (!resp_valid_q) begin
            resp_valid_q <= 1'b1;
          end else if (tlp_io.resp_ready) begin
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tlp_io.tlp_data   = tlp_data_q;
  assign tlp_io.tlp_valid  = tlp_valid_q;
  assign tlp_io.tlp_last   = tlp_last_q;
  assign tlp_io.resp_byte  = resp_byte_q;
  assign tlp_io.resp_valid = resp_valid_q;
  assign tlp_io.busy       = busy_q;
  assign tlp_io.tlp_count  = tlp_count_q;

endmodule

// File: tb/tb_tlp_inject_builder.sv
// Scoreboard bench for tlp_inject_builder: directed frames push their
// hand-computed TLP words and ACK/NAK bytes into queues, and a monitor
// pops and compares them whenever the DUT hands a word or byte over.
module tb_tlp_inject_builder;

  localparam int TB_TIMEOUT = 200;

  logic pcie_clk = 1'b0;
  logic pcie_reset_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  int   ready_mode = 0;

  logic [32:0] exp_words[$];
  logic [7:0]  exp_resp[$];
  logic [7:0]  exp_tag = 8'd0;
  int          exp_count = 0;

  tlp_inject_builder_if bus();

  tlp_inject_builder #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .pcie_clk     (pcie_clk),
    .pcie_reset_n (pcie_reset_n),
    .tlp_io       (bus.master)
  );

  always #5 pcie_clk = ~pcie_clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    @(posedge pcie_clk); #1;
    bus.rx_byte = b;
    bus.rx_byte_valid = 1'b1;
    @(posedge pcie_clk); #1;
    bus.rx_byte_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [87:0] frame, input int nbytes);
    for (int i = 0; i < nbytes; i++) sendByte(frame[87-8*i -: 8]);
  endtask

  function automatic logic [87:0] buildFrame(input logic [7:0] opc, input logic [31:0] a, input logic [31:0] d);
    logic [7:0] c;
    c = opc ^ a[31:24] ^ a[23:16] ^ a[15:8] ^ a[7:0] ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
    return {8'hAA, opc, a, d, c};
  endfunction

  task automatic pushWrite(input logic [31:0] a, input logic [31:0] d, input logic [7:0] tag);
    exp_words.push_back({1'b0, 32'h4000_0001});
    exp_words.push_back({1'b0, 16'h0100, tag, 8'h0F});
    exp_words.push_back({1'b0, a});
    exp_words.push_back({1'b1, d});
    exp_resp.push_back(8'h06);
  endtask

  task automatic waitIdle(input int bound);
    logic done;
    done = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge pcie_clk);
      if (!bus.busy && exp_words.size() == 0 && exp_resp.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput("idle_reached", done, 1'b1);
  endtask

  // Downstream and UART TX ready generators
  initial begin
    bus.tlp_ready = 1'b1;
    bus.resp_ready = 1'b1;
    forever begin
      @(posedge pcie_clk); #1;
      if (ready_mode == 1) begin
        bus.tlp_ready = 1'($urandom_range(0, 1));
        bus.resp_ready = 1'($urandom_range(0, 1));
      end else begin
        bus.tlp_ready = 1'b1;
        bus.resp_ready = 1'b1;
      end
    end
  end

  // Monitor: pops expectations on every handshake and checks stall stability
  initial begin
    logic        tstall, rstall;
    logic [32:0] held_w;
    logic [7:0]  held_r;
    logic [32:0] ew;
    tstall = 1'b0;
    rstall = 1'b0;
    held_w = '0;
    held_r = '0;
    forever begin
      @(negedge pcie_clk);
      if (!pcie_reset_n) begin
        tstall = 1'b0;
        rstall = 1'b0;
      end else begin
        if (bus.tlp_valid) begin
          if (tstall) checkOutput("tlp_hold", {bus.tlp_last, bus.tlp_data}, held_w);
          if (bus.tlp_ready) begin
            checkOutput("tlp_word_expected", exp_words.size() > 0, 1'b1);
            if (exp_words.size() > 0) begin
              ew = exp_words.pop_front();
              checkOutput("tlp_word", {bus.tlp_last, bus.tlp_data}, ew);
            end
            tstall = 1'b0;
          end else begin
            tstall = 1'b1;
            held_w = {bus.tlp_last, bus.tlp_data};
          end
        end else begin
          if (tstall) checkOutput("tlp_valid_dropped", bus.tlp_valid, 1'b1);
          tstall = 1'b0;
        end
        if (bus.resp_valid) begin
          if (rstall) checkOutput("resp_hold", bus.resp_byte, held_r);
          if (bus.resp_ready) begin
            checkOutput("resp_expected", exp_resp.size() > 0, 1'b1);
            if (exp_resp.size() > 0) checkOutput("resp_byte", bus.resp_byte, exp_resp.pop_front());
            rstall = 1'b0;
          end else begin
            rstall = 1'b1;
            held_r = bus.resp_byte;
          end
        end else begin
          rstall = 1'b0;
        end
      end
    end
  end

  initial begin
    logic        found;
    logic [31:0] a, d;
    bus.rx_byte = 8'h00;
    bus.rx_byte_valid = 1'b0;

    // Reset state
    repeat (3) @(posedge pcie_clk);
    #1;
    checkOutput("rst_tlp_data", bus.tlp_data, 32'h0);
    checkOutput("rst_tlp_valid", bus.tlp_valid, 1'b0);
    checkOutput("rst_tlp_last", bus.tlp_last, 1'b0);
    checkOutput("rst_resp_byte", bus.resp_byte, 8'h00);
    checkOutput("rst_resp_valid", bus.resp_valid, 1'b0);
    checkOutput("rst_busy", bus.busy, 1'b0);
    checkOutput("rst_tlp_count", bus.tlp_count, 16'd0);
    @(negedge pcie_clk);
    pcie_reset_n = 1'b1;

    // Write frame with E+2 latency check
    pushWrite(32'h1000_0004, 32'hDEAD_BEEF, 8'h00);
    applyStimulus(88'hAA_01_10000004_DEADBEEF_37, 11);
    @(posedge pcie_clk); #1;
    checkOutput("wr_valid_e1", bus.tlp_valid, 1'b0);
    @(posedge pcie_clk); #1;
    checkOutput("wr_valid_e2", bus.tlp_valid, 1'b1);
    waitIdle(100);
    checkOutput("wr_tlp_count", bus.tlp_count, 16'd1);

    // Read frame, tag 1
    exp_words.push_back({1'b0, 32'h0000_0001});
    exp_words.push_back({1'b0, 32'h0100_010F});
    exp_words.push_back({1'b1, 32'h2000_0008});
    exp_resp.push_back(8'h06);
    applyStimulus(88'hAA_02_20000008_00000000_2A, 11);
    waitIdle(100);
    checkOutput("rd_tlp_count", bus.tlp_count, 16'd2);

    // Bad checksum, with NAK E+2 latency check
    exp_resp.push_back(8'h15);
    applyStimulus(88'hAA_01_10000004_DEADBEEF_38, 11);
    @(posedge pcie_clk); #1;
    checkOutput("nak_valid_e1", bus.resp_valid, 1'b0);
    @(posedge pcie_clk); #1;
    checkOutput("nak_valid_e2", bus.resp_valid, 1'b1);
    checkOutput("nak_no_tlp", bus.tlp_valid, 1'b0);
    waitIdle(100);

    // Bad opcode and misaligned address
    exp_resp.push_back(8'h15);
    applyStimulus(88'hAA_03_10000004_DEADBEEF_35, 11);
    waitIdle(100);
    exp_resp.push_back(8'h15);
    applyStimulus(88'hAA_01_10000005_DEADBEEF_36, 11);
    waitIdle(100);
    checkOutput("nak_tlp_count", bus.tlp_count, 16'd2);

    // Partial frame times out, then next frame parses with tag 2
    exp_resp.push_back(8'h15);
    applyStimulus(88'hAA_01_10000004_DEADBEEF_37, 5);
    waitIdle(TB_TIMEOUT + 100);
    checkOutput("timeout_busy", bus.busy, 1'b0);
    pushWrite(32'h1000_0004, 32'hDEAD_BEEF, 8'h02);
    applyStimulus(88'hAA_01_10000004_DEADBEEF_37, 11);
    waitIdle(100);
    checkOutput("post_timeout_count", bus.tlp_count, 16'd3);

    // Random backpressure, tag 3
    ready_mode = 1;
    pushWrite(32'h1000_0004, 32'hDEAD_BEEF, 8'h03);
    applyStimulus(88'hAA_01_10000004_DEADBEEF_37, 11);
    waitIdle(400);
    ready_mode = 0;
    checkOutput("stall_tlp_count", bus.tlp_count, 16'd4);

    // Stray byte in IDLE is dropped; sync value inside data is payload
    sendByte(8'h55);
    @(negedge pcie_clk);
    checkOutput("stray_busy", bus.busy, 1'b0);
    pushWrite(32'h1000_0004, 32'h0000_00AA, 8'h04);
    applyStimulus(88'hAA_01_10000004_000000AA_BF, 11);
    waitIdle(100);
    checkOutput("sync_data_count", bus.tlp_count, 16'd5);

    // Reset during word 2 of EMIT
    pushWrite(32'h1000_0004, 32'hDEAD_BEEF, 8'h05);
    applyStimulus(88'hAA_01_10000004_DEADBEEF_37, 11);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge pcie_clk);
      if (bus.tlp_valid && bus.tlp_data == 32'h1000_0004) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("reset_word2_seen", found, 1'b1);
    #1 pcie_reset_n = 1'b0;
    #1;
    checkOutput("arst_tlp_data", bus.tlp_data, 32'h0);
    checkOutput("arst_tlp_valid", bus.tlp_valid, 1'b0);
    checkOutput("arst_tlp_last", bus.tlp_last, 1'b0);
    checkOutput("arst_resp_valid", bus.resp_valid, 1'b0);
    checkOutput("arst_busy", bus.busy, 1'b0);
    checkOutput("arst_tlp_count", bus.tlp_count, 16'd0);
    exp_words.delete();
    exp_resp.delete();
    exp_tag = 8'd0;
    exp_count = 0;
    @(negedge pcie_clk);
    pcie_reset_n = 1'b1;

    // 257 writes: tags 00..FF then wrap to 00
    for (int i = 0; i < 257; i++) begin
      a = 32'h3000_0000 + 32'(i) * 32'd4;
      d = (32'(i) * 32'h0101_0101) ^ 32'hCAFE_0000;
      pushWrite(a, d, exp_tag);
      applyStimulus(buildFrame(8'h01, a, d), 11);
      waitIdle(100);
      exp_tag = exp_tag + 8'd1;
      exp_count++;
      if (i == 255) checkOutput("count_256", bus.tlp_count, 16'd256);
    end
    checkOutput("count_257", bus.tlp_count, 16'(exp_count));

    checkOutput("words_left", exp_words.size(), 0);
    checkOutput("resp_left", exp_resp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tlp_inject_builder.md
# tlp_inject_builder

Converts framed UART command bytes into a complete 32-bit PCIe memory TLP and offers it word by word to the passthrough/injection mux. It sits between the UART receive path and the TLP injection controller in the `pcie_clk` domain. It also returns a one-byte ACK/NAK to the UART transmit path for each frame.

## Interface
- `REQ_ID`, 16'h0100, requester ID placed in DW1[31:16]
- `SYNC_BYTE`, 8'hAA, frame start byte
- `TIMEOUT_CYCLES`, 125000, maximum idle gap between bytes inside a frame (1 ms at 125 MHz)

- `pcie_clk`  in  1  core clock
- `pcie_reset_n`  in  1  asynchronous, active-low reset
- `rx_byte`  in  8  received UART byte
- `rx_byte_valid`  in  1  one-cycle strobe, `rx_byte` valid
- `tlp_data`  out  32  TLP word
- `tlp_valid`  out  1  `tlp_data` valid
- `tlp_ready`  in  1  downstream accepts the word
- `tlp_last`  out  1  final word of the TLP
- `resp_byte`  out  8  0x06 ACK / 0x15 NAK
- `resp_valid`  out  1  `resp_byte` valid
- `resp_ready`  in  1  UART TX accepts the response
- `busy`  out  1  high in every state except IDLE
- `tlp_count`  out  16  TLPs fully emitted, wraps at 16 bits

## Operation
- Frame is 11 bytes: SYNC, OPC, A3 A2 A1 A0, D3 D2 D1 D0, CHK.
  - Address and data are big-endian.
  - CHK is the XOR of OPC through D0.
- OPC 0x01 builds a 32-bit MWr with 1 DW of payload, giving 4 words:
  - DW0 = 32'h4000_0001
  - DW1 = {`REQ_ID`, tag, 8'h0F}
  - DW2 = {A[31:2], 2'b00}
  - DW3 = D
- OPC 0x02 builds a 32-bit MRd of length 1, giving 3 words:
  - DW0 = 32'h0000_0001
  - DW1 and DW2 as for MWr
  - Data bytes are still received, then ignored.
- States and transitions:
  - IDLE:
    - A byte equal to `SYNC_BYTE` moves to COLLECT with the byte counter at 0.
    - Any other byte is dropped.
  - COLLECT: stores 10 bytes (counter 0..9) and computes a running XOR over bytes 0..8.
    - After byte 9 (CHK), go to CHECK.
    - A `SYNC_BYTE` value seen mid-frame is treated as data; the parser does not resync.
  - CHECK: lasts one cycle. Any of the following is an error, which sends 0x15 and moves to RESP with no TLP emitted:
    - XOR mismatch
    - OPC not 0x01 or 0x02
    - A[1:0] != 0
  - CHECK with no error moves to EMIT.
  - EMIT: outputs words 0..N-1, advancing only when `tlp_valid` && `tlp_ready`.
    - `tlp_last` is high on word N-1.
    - When the last word is accepted: tag += 1 (8-bit wrap), `tlp_count` += 1, load ACK 0x06, go to RESP.
  - RESP: holds `resp_valid` until `resp_ready`, then goes to IDLE.
- Inter-byte timeout in COLLECT:
  - The counter clears on each `rx_byte_valid`.
  - If it reaches `TIMEOUT_CYCLES`-1 with no byte, load NAK 0x15 and go to RESP. The partial frame is discarded.
- Bytes arriving in CHECK, EMIT or RESP are dropped silently.
- The tag starts at 0 after reset. One tag value is consumed per emitted TLP; NAKed frames do not consume a tag.

## Timing
- Reset values:
  - `tlp_data` = 0, `tlp_valid` = 0, `tlp_last` = 0
  - `resp_byte` = 0, `resp_valid` = 0
  - `busy` = 0, `tlp_count` = 0, tag = 0
  - State = IDLE
- All outputs are registered.
- CHK is sampled at edge E. CHECK is active in the cycle after E. `tlp_valid` rises at edge E+2.
  - NAK case: `resp_valid` rises at edge E+2.
- With `tlp_ready` held high, one word is transferred per cycle. `resp_valid` rises on the edge after the last word's handshake.
- While `tlp_valid` && !`tlp_ready`, `tlp_data` and `tlp_last` are held stable. `tlp_valid` never drops before the handshake.
- `resp_byte` is stable while `resp_valid` is high.
- Asynchronous reset mid-frame or mid-EMIT:
  - All outputs clear immediately.
  - The partial TLP is abandoned.
  - The downstream mux must discard any incomplete TLP.

## Test plan
- Write frame AA 01 10 00 00 04 DE AD BE EF 37, `tlp_ready`=1:
  - Words 40000001, 0100000F, 10000004, DEADBEEF, with `tlp_last` on the 4th word.
  - Then `resp_byte`=06 and `tlp_count`=1.
- Read frame AA 02 20 00 00 08 00 00 00 00 2A, sent after the write frame:
  - Words 00000001, 0100010F (tag 1), 20000008, with `tlp_last` on the 3rd word.
  - Then ACK.
- Write frame with CHK=0x38 → NAK 15, `tlp_valid` never asserted, tag unchanged.
- Frame stopped after 5 bytes, idle for `TIMEOUT_CYCLES`:
  - NAK 15, `busy` returns to 0.
  - The next valid frame is parsed correctly.
- Write frame with `tlp_ready` toggling randomly:
  - Word order and values match the write-frame case.
  - Data is held stable during stalls.
- 256 consecutive write frames → tag in DW1[15:8] wraps from FF to 00, `tlp_count`=256.
- Reset asserted during word 2 of EMIT → all outputs 0 within the same cycle; a following frame uses tag 0.
